// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: RV32I control types shared by the sequencer, its timer and the decoder interface.
// Rev 1.0
`default_nettype none

package core_sequencer_pkg;

  localparam int unsigned c_timer_w = 16;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_IWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_MWAIT  = 4'd6,
    S_WB     = 4'd7,
    S_ERR    = 4'd8
  } ctrl_state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_from_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic {
    REG_NO = 1'b0,
    REG_WE = 1'b1
  } reg_we_e;

  // States in which the sequencer is blocked on a memory handshake.
  function automatic logic is_wait_state(input ctrl_state_e s);
    return (s == S_FETCH) || (s == S_IWAIT) || (s == S_MEM) || (s == S_MWAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: cycle counter with clear/enable and an expiry flag at a programmable limit.
// Rev 1.0
`default_nettype none

module ctrl_wait_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // r_count holds the number of earlier cycles spent in the current wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // A zero limit disables expiry.
  assign o_expired = i_enable && (i_limit != '0) && (r_count == (i_limit - WIDTH'(1)));

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I fetch/decode/execute/mem/writeback control FSM.
// Rev 1.0
`default_nettype none

module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  wb_from_e    wb_from,
  input  mem_op_e     mem_op,
  input  reg_we_e     r_we,
  input  reg_we_e     csr_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  output logic        pc_we,
  output logic        rf_we,
  output logic        csr_we_o,
  output logic [63:0] instret,
  output logic        err,
  output ctrl_state_e state
);

  localparam logic [c_timer_w-1:0] c_wait_limit = c_timer_w'(WAIT_TIMEOUT);

  ctrl_state_e r_state;
  ctrl_state_e w_next;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic [63:0] r_instret;
  logic        r_err;
  logic        w_expired;
  logic        w_in_wait;
  logic        w_timer_clear;
  logic        w_mem_access;

  assign w_mem_access  = (wb_from == WB_MEM) || (mem_op == MEM_STORE);
  assign w_in_wait     = is_wait_state(r_state);
  assign w_timer_clear = (w_next != r_state);

  ctrl_wait_timer #(
    .WIDTH (c_timer_w)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clear),
    .i_enable  (w_in_wait),
    .i_limit   (c_wait_limit),
    .o_expired (w_expired)
  );

  // A handshake completing in the same cycle the timer expires takes priority.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_gnt)       w_next = S_IWAIT;
        else if (w_expired) w_next = S_ERR;
      end
      S_IWAIT: begin
        if (imem_rvalid)    w_next = S_DECODE;
        else if (w_expired) w_next = S_ERR;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = w_mem_access ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_gnt)       w_next = S_MWAIT;
        else if (w_expired) w_next = S_ERR;
      end
      S_MWAIT: begin
        if (dmem_rvalid)    w_next = S_WB;
        else if (w_expired) w_next = S_ERR;
      end
      S_WB:     w_next = run ? S_FETCH : S_IDLE;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ir       <= NOP_INSTR;
      r_ir_valid <= 1'b0;
      r_instret  <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IWAIT) && imem_rvalid) begin
        r_ir       <= imem_rdata;
        r_ir_valid <= 1'b1;
      end
      if (r_state == S_WB) begin
        r_instret  <= r_instret + 64'd1;
        r_ir_valid <= 1'b0;
      end
      if (w_next == S_ERR) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_req = (r_state == S_FETCH);
  assign dmem_req = (r_state == S_MEM);
  assign dmem_we  = dmem_req && (mem_op == MEM_STORE);
  assign pc_we    = (r_state == S_WB);
  assign rf_we    = pc_we && (r_we == REG_WE);
  assign csr_we_o = pc_we && (csr_we == REG_WE);

  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign instret  = r_instret;
  assign err      = r_err;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench driving directed instructions through behavioural memories.
// Rev 1.0
`default_nettype none

module tb_core_sequencer;
  import core_sequencer_pkg::*;

  typedef struct {
    logic [31:0] instr;
    wb_from_e    wb;
    mem_op_e     mop;
    reg_we_e     rwe;
    reg_we_e     cwe;
    int          ig;
    int          irl;
    int          dg;
    int          dr;
    logic        rf;
    logic        csr;
    logic        dreq;
    logic        dwe;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        rf;
    logic        csr;
    logic        dreq;
    logic        dwe;
    int          lat;
    logic [63:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata, ir;
  logic        ir_valid;
  wb_from_e    wb_from;
  mem_op_e     mem_op;
  reg_we_e     r_we, csr_we;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic        pc_we, rf_we, csr_we_o;
  logic [63:0] instret;
  logic        err;
  ctrl_state_e state;

  logic        rst2_n, run2;
  logic        imem_req2, ir_valid2, dmem_req2, dmem_we2, pc_we2, rf_we2, csr_we2, err2;
  logic [31:0] ir2;
  logic [63:0] instret2;
  ctrl_state_e state2;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] model_instret = 64'd0;
  vec_t        cur;
  vec_t        vecs[6];
  vec_t        vslow;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid),
    .wb_from(wb_from), .mem_op(mem_op), .r_we(r_we), .csr_we(csr_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .pc_we(pc_we), .rf_we(rf_we), .csr_we_o(csr_we_o),
    .instret(instret), .err(err), .state(state)
  );

  core_sequencer #(.WAIT_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst2_n), .run(run2),
    .imem_req(imem_req2), .imem_gnt(1'b0), .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .ir(ir2), .ir_valid(ir_valid2),
    .wb_from(WB_ALU), .mem_op(MEM_NONE), .r_we(REG_NO), .csr_we(REG_NO),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_gnt(1'b0), .dmem_rvalid(1'b0),
    .pc_we(pc_we2), .rf_we(rf_we2), .csr_we_o(csr_we2),
    .instret(instret2), .err(err2), .state(state2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input wb_from_e wb, input mem_op_e mop,
                              input reg_we_e rwe, input reg_we_e cwe, input int ig, input int irl,
                              input int dg, input int dr, input logic rf, input logic csr,
                              input logic dreq, input logic dwe, input int lat);
    vec_t v;
    v.instr = instr; v.wb = wb; v.mop = mop; v.rwe = rwe; v.cwe = cwe;
    v.ig = ig; v.irl = irl; v.dg = dg; v.dr = dr;
    v.rf = rf; v.csr = csr; v.dreq = dreq; v.dwe = dwe; v.lat = lat;
    return v;
  endfunction

  task automatic load(input vec_t v, input bit push);
    exp_t e;
    cur = v;
    wb_from = v.wb; mem_op = v.mop; r_we = v.rwe; csr_we = v.cwe;
    if (push) begin
      model_instret = model_instret + 64'd1;
      e.instr = v.instr; e.rf = v.rf; e.csr = v.csr; e.dreq = v.dreq; e.dwe = v.dwe;
      e.lat = v.lat; e.instret = model_instret;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_wb(input string tag);
    int n = 0;
    @(negedge clk);
    while (!pc_we && n < 200) begin @(negedge clk); n++; end
    if (!pc_we) begin
      n_chk++;
      $display("FAIL %s_wb_timeout: actual pc_we=0 required pc_we=1 within 200 cycles", tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input ctrl_state_e s, input string tag);
    int n = 0;
    @(negedge clk);
    while (state !== s && n < 200) begin @(negedge clk); n++; end
    if (state !== s) begin
      n_chk++;
      $display("FAIL %s_state_timeout: actual state=%0d required=%0d", tag, state, s);
    end
  endtask

  // Instruction memory: grant after ig cycles of request, data irl cycles after the grant.
  initial begin
    int ph, cnt;
    ph = 0; cnt = 0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      if (!rst_n) ph = 0;
      else begin
        case (ph)
          0: if (imem_req) begin
               if (cur.ig == 0) begin imem_gnt = 1'b1; ph = 2; cnt = cur.irl; end
               else begin ph = 1; cnt = cur.ig; end
             end
          1: begin cnt--; if (cnt == 0) begin imem_gnt = 1'b1; ph = 2; cnt = cur.irl; end end
          2: begin cnt--; if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = cur.instr; ph = 0; end end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin
    int ph, cnt;
    ph = 0; cnt = 0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (!rst_n) ph = 0;
      else begin
        case (ph)
          0: if (dmem_req) begin
               if (cur.dg == 0) begin dmem_gnt = 1'b1; ph = 2; cnt = cur.dr; end
               else begin ph = 1; cnt = cur.dg; end
             end
          1: begin cnt--; if (cnt == 0) begin dmem_gnt = 1'b1; ph = 2; cnt = cur.dr; end end
          2: begin cnt--; if (cnt == 0) begin dmem_rvalid = 1'b1; ph = 0; end end
          default: ph = 0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every writeback strobe.
  initial begin
    exp_t        e;
    int          fetch_cyc;
    logic        prev_ireq, sdreq, sdwe, pend;
    logic [63:0] pend_instret;
    fetch_cyc = 0; prev_ireq = 1'b0; sdreq = 1'b0; sdwe = 1'b0; pend = 1'b0; pend_instret = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ireq = 1'b0; sdreq = 1'b0; sdwe = 1'b0; pend = 1'b0;
      end else begin
        if (pend) begin
          check("instret_after_wb", instret, pend_instret);
          check("pc_we_one_cycle", 64'(pc_we), 64'd0);
          check("ir_valid_cleared", 64'(ir_valid), 64'd0);
          pend = 1'b0;
        end
        if (imem_req && !prev_ireq) fetch_cyc = cyc;
        prev_ireq = imem_req;
        if (dmem_req) begin sdreq = 1'b1; sdwe = dmem_we; end
        if (pc_we) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL retire_unexpected: actual=retire of %h required=no retire", ir);
          end else begin
            e = exp_q.pop_front();
            check("wb_ir", 64'(ir), 64'(e.instr));
            check("wb_ir_valid", 64'(ir_valid), 64'd1);
            check("wb_rf_we", 64'(rf_we), 64'(e.rf));
            check("wb_csr_we", 64'(csr_we_o), 64'(e.csr));
            check("dmem_req_seen", 64'(sdreq), 64'(e.dreq));
            check("dmem_we_seen", 64'(sdwe), 64'(e.dwe));
            check("wb_latency", 64'(cyc - fetch_cyc + 1), 64'(e.lat));
            pend = 1'b1;
            pend_instret = e.instret;
          end
          sdreq = 1'b0; sdwe = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(32'h0050_0093, WB_ALU, MEM_NONE,  REG_WE, REG_NO, 0, 1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    vecs[1] = mk(32'h0000_A103, WB_MEM, MEM_LOAD,  REG_WE, REG_NO, 0, 1, 3, 3, 1'b1, 1'b0, 1'b1, 1'b0, 12);
    vecs[2] = mk(32'h0020_A223, WB_ALU, MEM_STORE, REG_NO, REG_NO, 0, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 7);
    vecs[3] = mk(32'h0020_8463, WB_ALU, MEM_NONE,  REG_NO, REG_NO, 0, 1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    vecs[4] = mk(32'h3400_91F3, WB_CSR, MEM_NONE,  REG_WE, REG_WE, 0, 1, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    vecs[5] = mk(32'h0010_8093, WB_ALU, MEM_NONE,  REG_WE, REG_NO, 2, 2, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    vslow   = mk(32'h0040_A183, WB_MEM, MEM_LOAD,  REG_WE, REG_NO, 0, 1, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    cur = vecs[0];
    wb_from = WB_ALU; mem_op = MEM_NONE; r_we = REG_NO; csr_we = REG_NO;
    rst_n = 1'b0; run = 1'b0; rst2_n = 1'b0; run2 = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_state", 64'(state), 64'(S_IDLE));
    check("rst_ir", 64'(ir), 64'h13);
    check("rst_ir_valid", 64'(ir_valid), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_outputs", 64'({imem_req, dmem_req, dmem_we, pc_we, rf_we, csr_we_o}), 64'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hold_state", 64'(state), 64'(S_IDLE));
    check("idle_hold_req", 64'(imem_req), 64'd0);

    load(vecs[0], 1'b1);
    run = 1'b1;
    wait_wb("addi");
    for (int i = 1; i < 6; i++) begin
      load(vecs[i], 1'b1);
      wait_wb($sformatf("vec%0d", i));
    end

    // Dropping run mid-instruction still retires it, then parks in idle.
    load(vecs[0], 1'b1);
    wait_state(S_EXEC, "drop");
    run = 1'b0;
    wait_wb("drop");
    @(negedge clk);
    check("drop_idle_state", 64'(state), 64'(S_IDLE));
    check("drop_idle_req", 64'(imem_req), 64'd0);
    repeat (3) @(negedge clk);
    check("drop_idle_stay", 64'(state), 64'(S_IDLE));
    load(vecs[4], 1'b1);
    run = 1'b1;
    @(negedge clk);
    check("restart_fetch", 64'(state), 64'(S_FETCH));
    check("restart_req", 64'(imem_req), 64'd1);
    run = 1'b0;
    wait_wb("restart");

    load(vslow, 1'b0);
    run = 1'b1;
    wait_state(S_MWAIT, "midrst");
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 64'(state), 64'(S_IDLE));
    check("midrst_ir", 64'(ir), 64'h13);
    check("midrst_instret", instret, 64'd0);
    check("midrst_dmem_req", 64'(dmem_req), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_instret = 64'd0;

    @(negedge clk);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.r_instret;
    @(negedge clk);
    check("preset_instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    model_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    load(vecs[0], 1'b1);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_wb("wrap");
    repeat (2) @(negedge clk);

    run2 = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!imem_req2 && n < 20) begin @(negedge clk); n++; end
      check("to_fetch_entry", 64'(imem_req2), 64'd1);
    end
    repeat (3) @(negedge clk);
    check("to_still_fetch", 64'(state2), 64'(S_FETCH));
    check("to_err_pre", 64'(err2), 64'd0);
    @(negedge clk);
    check("to_err_state", 64'(state2), 64'(S_ERR));
    check("to_err_flag", 64'(err2), 64'd1);
    check("to_err_req", 64'(imem_req2), 64'd0);
    run2 = 1'b0;
    repeat (3) @(negedge clk);
    check("to_err_sticky", 64'({err2, state2}), 64'({1'b1, S_ERR}));
    rst2_n = 1'b0;
    #1;
    check("to_rst_err", 64'(err2), 64'd0);
    check("to_rst_state", 64'(state2), 64'(S_IDLE));
    @(negedge clk);
    rst2_n = 1'b1;

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
